// File: rtl/oam_dma_engine.sv
// OAM DMA engine.
// A CPU write to the DMA register latches a source page and starts a copy of
// OAM_BYTES bytes from {page, idx} into OAM_BASE + idx. Each byte is a read
// request followed by a write request on the initiator port. A register write
// that arrives during a copy restarts it from byte 0 with the new page once
// the outstanding request has been acknowledged.
// The register can be read back at any time without disturbing the copy.

module oam_dma_engine #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter int          OAM_BYTES    = 160
) (
    input  logic        clk,
    input  logic        reset_n,
    // responder (CPU register) side
    input  logic [15:0] s_addr,
    input  logic [7:0]  s_wdata,
    input  logic        s_write,
    input  logic        s_read,
    output logic [7:0]  s_rdata,
    output logic        s_rd_en,
    // initiator (memory) side
    output logic        m_req,
    output logic        m_we,
    output logic [15:0] m_addr,
    output logic [7:0]  m_wdata,
    input  logic [7:0]  m_rdata,
    input  logic        m_ack,
    // status
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    // Index of the final byte of a transfer.
    localparam logic [7:0] IDX_LAST = 8'(OAM_BYTES - 1);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [7:0]  r_src_page;
    logic [7:0]  r_idx;
    logic [7:0]  r_data;
    logic        r_restart;
    logic        r_m_req;
    logic        r_m_we;
    logic [15:0] r_m_addr;
    logic [7:0]  r_m_wdata;
    logic [7:0]  r_s_rdata;
    logic        r_s_rd_en;
    logic        r_busy;
    logic        r_done;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic [1:0]  w_state_nx;
    logic [7:0]  w_src_page_nx;
    logic [7:0]  w_idx_nx;
    logic [7:0]  w_data_nx;
    logic        w_restart_nx;
    logic        w_m_req_nx;
    logic        w_m_we_nx;
    logic [15:0] w_m_addr_nx;
    logic [7:0]  w_m_wdata_nx;
    logic [7:0]  w_s_rdata_nx;
    logic        w_s_rd_en_nx;
    logic        w_busy_nx;
    logic        w_done_nx;

    // ------------------------------------------------------------------
    // Decoded events
    // ------------------------------------------------------------------
    logic        w_reg_wr;
    logic        w_reg_rd;
    logic        w_xfer;
    logic        w_restart_now;
    logic [7:0]  w_page_eff;
    logic [7:0]  w_idx_inc;
    logic [15:0] w_oam_addr;

    assign w_reg_wr      = s_write && (s_addr == DMA_REG_ADDR);
    assign w_reg_rd      = s_read  && (s_addr == DMA_REG_ADDR);
    assign w_xfer        = r_m_req && m_ack;
    // A write landing on the same edge as an ack takes effect immediately,
    // so the restart decision and the new page both look at it directly.
    assign w_restart_now = r_restart || w_reg_wr;
    assign w_page_eff    = w_reg_wr ? s_wdata : r_src_page;
    assign w_idx_inc     = r_idx + 8'd1;
    // Destination address is formed in 16 bits so OAM_BASE + idx never wraps
    // inside the low byte.
    assign w_oam_addr    = OAM_BASE + {8'h00, r_idx};

    // Register read-back path: independent of the copy state machine.
    always_comb begin
        w_s_rd_en_nx = w_reg_rd;
        w_s_rdata_nx = r_s_rdata;
        if (w_reg_rd) begin
            w_s_rdata_nx = r_src_page;
        end else begin
            w_s_rdata_nx = r_s_rdata;
        end
    end

    // Copy state machine: computes next state and next initiator request.
    always_comb begin
        w_state_nx    = r_state;
        w_src_page_nx = w_page_eff;
        w_idx_nx      = r_idx;
        w_data_nx     = r_data;
        w_restart_nx  = r_restart;
        w_m_req_nx    = r_m_req;
        w_m_we_nx     = r_m_we;
        w_m_addr_nx   = r_m_addr;
        w_m_wdata_nx  = r_m_wdata;
        w_done_nx     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_restart_nx = 1'b0;
                if (w_reg_wr) begin
                    // Start a fresh copy; first read goes out next cycle.
                    w_state_nx  = ST_RD;
                    w_idx_nx    = 8'd0;
                    w_m_req_nx  = 1'b1;
                    w_m_we_nx   = 1'b0;
                    w_m_addr_nx = {s_wdata, 8'h00};
                end else begin
                    w_m_req_nx  = 1'b0;
                    w_m_we_nx   = 1'b0;
                end
            end

            ST_RD: begin
                if (w_xfer) begin
                    if (w_restart_now) begin
                        // Read completed but the copy was superseded:
                        // drop the byte and start over from index 0.
                        w_state_nx   = ST_RD;
                        w_idx_nx     = 8'd0;
                        w_restart_nx = 1'b0;
                        w_m_req_nx   = 1'b1;
                        w_m_we_nx    = 1'b0;
                        w_m_addr_nx  = {w_page_eff, 8'h00};
                    end else begin
                        w_state_nx   = ST_WR;
                        w_data_nx    = m_rdata;
                        w_m_req_nx   = 1'b1;
                        w_m_we_nx    = 1'b1;
                        w_m_addr_nx  = w_oam_addr;
                        w_m_wdata_nx = m_rdata;
                    end
                end else begin
                    // Request held stable; only remember a pending restart.
                    if (w_reg_wr) begin
                        w_restart_nx = 1'b1;
                    end else begin
                        w_restart_nx = r_restart;
                    end
                end
            end

            ST_WR: begin
                if (w_xfer) begin
                    if (w_restart_now) begin
                        w_state_nx   = ST_RD;
                        w_idx_nx     = 8'd0;
                        w_restart_nx = 1'b0;
                        w_m_req_nx   = 1'b1;
                        w_m_we_nx    = 1'b0;
                        w_m_addr_nx  = {w_page_eff, 8'h00};
                    end else if (r_idx == IDX_LAST) begin
                        w_state_nx   = ST_IDLE;
                        w_m_req_nx   = 1'b0;
                        w_m_we_nx    = 1'b0;
                        w_done_nx    = 1'b1;
                    end else begin
                        w_state_nx   = ST_RD;
                        w_idx_nx     = w_idx_inc;
                        w_m_req_nx   = 1'b1;
                        w_m_we_nx    = 1'b0;
                        w_m_addr_nx  = {r_src_page, w_idx_inc};
                    end
                end else begin
                    if (w_reg_wr) begin
                        w_restart_nx = 1'b1;
                    end else begin
                        w_restart_nx = r_restart;
                    end
                end
            end

            default: begin
                // Unreachable encoding: park safely with no request.
                w_state_nx   = ST_IDLE;
                w_idx_nx     = 8'd0;
                w_restart_nx = 1'b0;
                w_m_req_nx   = 1'b0;
                w_m_we_nx    = 1'b0;
            end
        endcase

        w_busy_nx = (w_state_nx != ST_IDLE);
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_src_page <= 8'h00;
            r_idx      <= 8'd0;
            r_data     <= 8'h00;
            r_restart  <= 1'b0;
            r_m_req    <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= 16'h0000;
            r_m_wdata  <= 8'h00;
            r_s_rdata  <= 8'h00;
            r_s_rd_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_src_page <= w_src_page_nx;
            r_idx      <= w_idx_nx;
            r_data     <= w_data_nx;
            r_restart  <= w_restart_nx;
            r_m_req    <= w_m_req_nx;
            r_m_we     <= w_m_we_nx;
            r_m_addr   <= w_m_addr_nx;
            r_m_wdata  <= w_m_wdata_nx;
            r_s_rdata  <= w_s_rdata_nx;
            r_s_rd_en  <= w_s_rd_en_nx;
            r_busy     <= w_busy_nx;
            r_done     <= w_done_nx;
        end
    end

    assign s_rdata = r_s_rdata;
    assign s_rd_en = r_s_rd_en;
    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Testbench for oam_dma_engine: a memory responder with tied-high or random
// ack delays, a transaction log, and a reference model that lists the bus
// transactions a copy (or a truncated copy followed by a restart) must make.

module tb_oam_dma_engine;

    localparam logic [15:0] REG_ADDR  = 16'hFF46;
    localparam logic [15:0] OAM_BASE  = 16'hFE00;
    localparam int          OAM_BYTES = 160;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] s_addr;
    logic [7:0]  s_wdata;
    logic        s_write;
    logic        s_read;
    logic [7:0]  s_rdata;
    logic        s_rd_en;
    logic        m_req;
    logic        m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata;
    logic        m_ack;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    // responder controls and monitors
    int          ack_mode = 0;   // 0: ack tied high, 1: random 0-5 cycle delay
    logic        hold_ack = 1'b0;
    int          dly = 0;
    logic        stall_prev = 1'b0;
    logic        prev_we;
    logic [15:0] prev_addr;
    logic [7:0]  prev_wdata;
    int          req_cycles = 0;
    int          busy_cycles = 0;
    int          done_cnt = 0;

    logic [7:0] src_mem [0:65535];
    logic [7:0] oam     [0:OAM_BYTES-1];
    txn_t       log_q[$];
    txn_t       exp_q[$];

    oam_dma_engine #(
        .DMA_REG_ADDR(REG_ADDR),
        .OAM_BASE    (OAM_BASE),
        .OAM_BYTES   (OAM_BYTES)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_write(s_write), .s_read(s_read),
        .s_rdata(s_rdata), .s_rd_en(s_rd_en),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memory responder: decides ack for the next rising edge, logs transfers
    // that will complete there, and checks request stability while stalled.
    always @(negedge clk) begin
        m_rdata = 8'($urandom);
        if (m_req) begin
            if (stall_prev) begin
                n_vec++;
                if (m_we !== prev_we || m_addr !== prev_addr || m_wdata !== prev_wdata) begin
                    n_err++;
                    $display("FAIL stable: got we=%0b addr=%h wdata=%h, want we=%0b addr=%h wdata=%h",
                             m_we, m_addr, m_wdata, prev_we, prev_addr, prev_wdata);
                end
            end else begin
                dly = (ack_mode == 0) ? 0 : int'($urandom_range(0, 5));
            end
            if (hold_ack) begin
                m_ack = 1'b0;
            end else if (dly == 0) begin
                m_ack = 1'b1;
            end else begin
                m_ack = 1'b0;
                dly--;
            end
            req_cycles++;
            if (m_ack) begin
                if (m_we) begin
                    log_q.push_back('{1'b1, m_addr, m_wdata});
                    if (m_addr >= OAM_BASE && m_addr < OAM_BASE + 16'(OAM_BYTES))
                        oam[m_addr - OAM_BASE] = m_wdata;
                end else begin
                    m_rdata = src_mem[m_addr];
                    log_q.push_back('{1'b0, m_addr, src_mem[m_addr]});
                end
            end
            stall_prev = !m_ack;
            prev_we    = m_we;
            prev_addr  = m_addr;
            prev_wdata = m_wdata;
        end else begin
            stall_prev = 1'b0;
            m_ack = (ack_mode == 0) ? 1'b1 : 1'b0;
        end
        if (busy) busy_cycles++;
        if (done) done_cnt++;
    end

    // Reference model: expected transaction list for the first nent transfers
    // of a copy from the given page.
    function automatic void model_copy(input logic [7:0] page, input int nent);
        for (int e = 0; e < nent; e++) begin
            int          i;
            logic [15:0] src;
            txn_t        t;
            i      = e / 2;
            src    = {page, 8'(i)};
            t.data = src_mem[src];
            if (e % 2 == 0) begin
                t.we   = 1'b0;
                t.addr = src;
            end else begin
                t.we   = 1'b1;
                t.addr = OAM_BASE + 16'(i);
            end
            exp_q.push_back(t);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_run();
        log_q.delete();
        exp_q.delete();
        req_cycles  = 0;
        busy_cycles = 0;
        done_cnt    = 0;
        for (int i = 0; i < OAM_BYTES; i++) oam[i] = 'x;
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
        s_write = 1'b1;
        s_addr  = a;
        s_wdata = d;
        step();
        s_write = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        for (int c = 0; c < limit && busy; c++) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({m_req, m_we, m_addr, m_wdata, s_rdata, s_rd_en, busy, done} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_vals: got req=%0b we=%0b addr=%h wd=%h rd=%h rden=%0b busy=%0b done=%0b, want all 0",
                     m_req, m_we, m_addr, m_wdata, s_rdata, s_rd_en, busy, done);
        end
        step(); step();
        reset_n = 1'b1;
        step(); step();
        n_vec++;
        if (m_req !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got req=%0b busy=%0b, want 0 0", m_req, busy);
        end
    endtask

    task automatic test_basic();
        logic [7:0] pg;
        pg = 8'hC1;
        clear_run();
        ack_mode = 0;
        reg_write(REG_ADDR, pg);
        n_vec++;
        if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 16'hC100 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_start: got req=%0b we=%0b addr=%h busy=%0b, want 1 0 c100 1",
                     m_req, m_we, m_addr, busy);
        end
        wait_idle(1000);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            n_err++;
            $display("FAIL basic_done: got busy=%0b done=%0b, want 0 1", busy, done);
        end
        step(); step();
        n_vec++;
        if (done_cnt !== 1 || busy_cycles !== 2 * OAM_BYTES || req_cycles !== 2 * OAM_BYTES) begin
            n_err++;
            $display("FAIL basic_timing: got done=%0d busy=%0d req=%0d, want 1 %0d %0d",
                     done_cnt, busy_cycles, req_cycles, 2 * OAM_BYTES, 2 * OAM_BYTES);
        end
        model_copy(pg, 2 * OAM_BYTES);
        n_vec++;
        if (log_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL basic_len: got %0d, want %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_vec++;
            if (log_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL basic_txn[%0d]: got we=%0b addr=%h data=%h, want we=%0b addr=%h data=%h",
                         i, log_q[i].we, log_q[i].addr, log_q[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_random_ack();
        for (int it = 0; it < 3; it++) begin
            logic [7:0] pg;
            pg = 8'($urandom);
            clear_run();
            ack_mode = 1;
            reg_write(REG_ADDR, pg);
            wait_idle(5000);
            n_vec++;
            if (busy !== 1'b0 || done !== 1'b1) begin
                n_err++;
                $display("FAIL rand_done[%0d]: got busy=%0b done=%0b, want 0 1", it, busy, done);
            end
            step(); step();
            for (int i = 0; i < OAM_BYTES; i++) begin
                n_vec++;
                if (oam[i] !== src_mem[{pg, 8'(i)}]) begin
                    n_err++;
                    $display("FAIL rand_oam[%0d]: got %h, want %h", i, oam[i], src_mem[{pg, 8'(i)}]);
                end
            end
            n_vec++;
            if (done_cnt !== 1 || log_q.size() !== 2 * OAM_BYTES) begin
                n_err++;
                $display("FAIL rand_count[%0d]: got done=%0d txns=%0d, want 1 %0d",
                         it, done_cnt, log_q.size(), 2 * OAM_BYTES);
            end
        end
        ack_mode = 0;
    endtask

    task automatic test_restart();
        int found;
        clear_run();
        ack_mode = 1;
        found = 0;
        reg_write(REG_ADDR, 8'hC1);
        for (int c = 0; c < 3000 && found == 0; c++) begin
            if (m_req && !m_we && m_addr == 16'hC132) found = 1;
            else step();
        end
        n_vec++;
        if (found == 0) begin
            n_err++;
            $display("FAIL restart_find: got no read of c132, want one");
        end
        hold_ack = 1'b1;
        step();
        reg_write(REG_ADDR, 8'hD0);
        n_vec++;
        if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 16'hC132) begin
            n_err++;
            $display("FAIL restart_hold: got req=%0b we=%0b addr=%h, want 1 0 c132", m_req, m_we, m_addr);
        end
        hold_ack = 1'b0;
        wait_idle(6000);
        step(); step();
        model_copy(8'hC1, 2 * 50 + 1);
        model_copy(8'hD0, 2 * OAM_BYTES);
        n_vec++;
        if (log_q.size() !== exp_q.size() || done_cnt !== 1) begin
            n_err++;
            $display("FAIL restart_len: got txns=%0d done=%0d, want %0d 1", log_q.size(), done_cnt, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_vec++;
            if (log_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL restart_txn[%0d]: got we=%0b addr=%h data=%h, want we=%0b addr=%h data=%h",
                         i, log_q[i].we, log_q[i].addr, log_q[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
            end
        end
        ack_mode = 0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] pa;
        logic [7:0] pb;
        logic [7:0] pc;
        int k;
        int r;
        pa = 8'($urandom);
        pb = 8'($urandom);
        pc = 8'($urandom);
        r  = int'($urandom_range(5, 300));
        clear_run();
        ack_mode = 0;
        reg_write(REG_ADDR, pa);
        for (int c = 0; c < r; c++) step();
        // register write coincides with an ack (ack is tied high)
        reg_write(REG_ADDR, pb);
        k = log_q.size();
        n_vec++;
        if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== {pb, 8'h00}) begin
            n_err++;
            $display("FAIL b2b_restart: got req=%0b we=%0b addr=%h, want 1 0 %h", m_req, m_we, m_addr, {pb, 8'h00});
        end
        wait_idle(1000);
        // second copy starts in the cycle done is high
        reg_write(REG_ADDR, pc);
        wait_idle(1000);
        step(); step();
        model_copy(pa, k);
        model_copy(pb, 2 * OAM_BYTES);
        model_copy(pc, 2 * OAM_BYTES);
        n_vec++;
        if (log_q.size() !== exp_q.size() || done_cnt !== 2) begin
            n_err++;
            $display("FAIL b2b_len: got txns=%0d done=%0d, want %0d 2", log_q.size(), done_cnt, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_vec++;
            if (log_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL b2b_txn[%0d]: got we=%0b addr=%h data=%h, want we=%0b addr=%h data=%h",
                         i, log_q[i].we, log_q[i].addr, log_q[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_reset_midcopy();
        int found;
        clear_run();
        ack_mode = 0;
        found = 0;
        reg_write(REG_ADDR, 8'hC1);
        for (int c = 0; c < 1000 && found == 0; c++) begin
            if (m_req && m_we && m_addr == 16'hFE0A) found = 1;
            else step();
        end
        n_vec++;
        if (found == 0) begin
            n_err++;
            $display("FAIL rst_find: got no write of fe0a, want one");
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (m_req !== 1'b0 || busy !== 1'b0 || m_we !== 1'b0 || m_addr !== 16'h0000 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_async: got req=%0b busy=%0b we=%0b addr=%h done=%0b, want 0 0 0 0000 0",
                     m_req, busy, m_we, m_addr, done);
        end
        step(); step();
        reset_n = 1'b1;
        req_cycles = 0;
        for (int c = 0; c < 40; c++) step();
        n_vec++;
        if (req_cycles !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_quiet: got req_cycles=%0d busy=%0b, want 0 0", req_cycles, busy);
        end
        s_read = 1'b1;
        s_addr = REG_ADDR;
        step();
        s_read = 1'b0;
        n_vec++;
        if (s_rd_en !== 1'b1 || s_rdata !== 8'h00) begin
            n_err++;
            $display("FAIL rst_page: got rden=%0b rdata=%h, want 1 00", s_rd_en, s_rdata);
        end
        // a write to a neighbouring address must not start a copy
        reg_write(REG_ADDR + 16'd1, 8'h55);
        step();
        n_vec++;
        if (busy !== 1'b0 || m_req !== 1'b0) begin
            n_err++;
            $display("FAIL other_addr: got busy=%0b req=%0b, want 0 0", busy, m_req);
        end
    endtask

    task automatic test_read();
        clear_run();
        ack_mode = 0;
        reg_write(REG_ADDR, 8'h80);
        for (int n = 0; n < 6; n++) begin
            int gap;
            gap = int'($urandom_range(0, 40));
            for (int c = 0; c < gap; c++) step();
            s_read = 1'b1;
            s_addr = (n == 3) ? REG_ADDR + 16'd1 : REG_ADDR;
            step();
            s_read = 1'b0;
            n_vec++;
            if (n == 3) begin
                if (s_rd_en !== 1'b0) begin
                    n_err++;
                    $display("FAIL read_miss: got rden=%0b, want 0", s_rd_en);
                end
            end else if (s_rd_en !== 1'b1 || s_rdata !== 8'h80) begin
                n_err++;
                $display("FAIL read_hit[%0d]: got rden=%0b rdata=%h, want 1 80", n, s_rd_en, s_rdata);
            end
            step();
            n_vec++;
            if (s_rd_en !== 1'b0) begin
                n_err++;
                $display("FAIL read_pulse[%0d]: got rden=%0b, want 0", n, s_rd_en);
            end
        end
        wait_idle(1000);
        step(); step();
        n_vec++;
        if (req_cycles !== 2 * OAM_BYTES || done_cnt !== 1) begin
            n_err++;
            $display("FAIL read_timing: got req=%0d done=%0d, want %0d 1", req_cycles, done_cnt, 2 * OAM_BYTES);
        end
        model_copy(8'h80, 2 * OAM_BYTES);
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_vec++;
            if (log_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL read_txn[%0d]: got we=%0b addr=%h data=%h, want we=%0b addr=%h data=%h",
                         i, log_q[i].we, log_q[i].addr, log_q[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) src_mem[a] = 8'($urandom);
        reset_n = 1'b0;
        s_addr  = 16'h0000;
        s_wdata = 8'h00;
        s_write = 1'b0;
        s_read  = 1'b0;
        m_rdata = 8'h00;
        m_ack   = 1'b0;
        test_reset();
        test_basic();
        test_random_ack();
        test_restart();
        test_back_to_back();
        test_reset_midcopy();
        test_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/oam_dma_engine.md
OAM_DMA_ENGINE -- requirements
Module: oam_dma_engine

Interface
REQ-001 Parameter DMA_REG_ADDR, default 16'hFF46, meaning: CPU-visible DMA source-page register address.
REQ-002 Parameter OAM_BASE, default 16'hFE00, meaning: first OAM destination address.
REQ-003 Parameter OAM_BYTES, default 160, meaning: bytes copied per transfer.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 s_addr  input  16  responder-side bus address.
REQ-007 s_wdata  input  8  responder-side write data.
REQ-008 s_write  input  1  responder-side write strobe, sampled at clk.
REQ-009 s_read  input  1  responder-side read strobe, sampled at clk.
REQ-010 s_rdata  output  8  registered read data for DMA_REG_ADDR.
REQ-011 s_rd_en  output  1  high for one cycle after a read hit; the bus drives s_rdata only while this is high.
REQ-012 m_req  output  1  initiator request; held until acknowledged.
REQ-013 m_we  output  1  initiator direction: 1 = write, 0 = read.
REQ-014 m_addr  output  16  initiator address.
REQ-015 m_wdata  output  8  initiator write data.
REQ-016 m_rdata  input  8  initiator read data; valid in the cycle m_ack is high on a read.
REQ-017 m_ack  input  1  initiator acknowledge; a transfer completes on a rising edge where m_req and m_ack are both high.
REQ-018 busy  output  1  high while a copy is in progress.
REQ-019 done  output  1  one-cycle pulse after the final OAM write completes.

Function
REQ-020 Storage: an 8-bit source-page register src_page and an 8-bit index idx (0..OAM_BYTES-1).
- A write with s_addr==DMA_REG_ADDR loads src_page from s_wdata.
- Reads of DMA_REG_ADDR return src_page.
REQ-021 State machine: IDLE, RD, WR.
- IDLE->RD on a register write; idx cleared.
- RD->WR on ack; m_rdata is captured into an 8-bit data latch.
- WR->RD on ack when idx<OAM_BYTES-1; idx increments.
- WR->IDLE on ack when idx==OAM_BYTES-1; done pulses in the following cycle.
REQ-022 RD phase: m_req=1, m_we=0, m_addr={src_page, idx}.
REQ-023 WR phase: m_req=1, m_we=1, m_addr=OAM_BASE+idx, m_wdata equal to the latched data.
REQ-024 Handshake stability: m_req, m_we, m_addr and m_wdata are registered and do not change while m_req=1 and m_ack=0.
REQ-025 In IDLE, m_req and m_we are 0.
REQ-026 Latency:
- m_req rises in the cycle after the register-write edge.
- After an ack edge, the next request is presented in the immediately following cycle; there are no idle bubbles.
- With m_ack tied high, a full copy takes exactly 2*OAM_BYTES cycles of m_req.
REQ-027 busy=1 in RD and WR states; busy=0 in IDLE.
REQ-028 Restart: a register write while busy updates src_page and sets a restart flag. The outstanding request still completes by ack. On that ack the engine enters RD with idx=0 under the new src_page; no OAM write is issued for the aborted byte, and done does not pulse.
REQ-029 Simultaneous register write and m_ack in the same cycle: the ack completes the current transfer, and the restart applies on that same edge.
REQ-030 idx arithmetic: m_addr for WR is computed in 16 bits with no wrap. idx never exceeds OAM_BYTES-1.
REQ-031 The register read path operates in every state and never stalls the copy.

Reset
REQ-032 When reset_n is low, outputs are forced immediately (asynchronously) to: state=IDLE, src_page=0, idx=0, data latch=0, restart=0, m_req=0, m_we=0, m_addr=0, m_wdata=0, s_rdata=0, s_rd_en=0, busy=0, done=0.
REQ-033 Reset asserted mid-copy abandons the transfer with no further requests. After release, the engine stays in IDLE until a new register write.

Verification
REQ-034 Write 8'hC1 to 16'hFF46 with m_ack tied high -> reads of C100..C19F are interleaved with writes to FE00..FE9F, carrying matching data. busy is high for 320 cycles, then done pulses once.
REQ-035 Random 0-5 cycle ack delays -> m_addr/m_we/m_wdata are stable while m_req && !m_ack, and OAM contents equal the source page.
REQ-036 Write 8'hC1, then write 8'hD0 at idx=50 during a pending read -> no write to FE32 from C132. The copy restarts at D000 to FE00, and exactly one done pulse follows the final write to FE9F.
REQ-037 Deassert reset_n while in WR at idx=10 -> m_req=0, busy=0 and src_page=0 in the same cycle. No requests occur afterwards until a new register write.
REQ-038 Read 16'hFF46 after writing 8'h80, including mid-copy -> s_rdata=8'h80 with s_rd_en high for one cycle, and the copy timing is unaffected.
